// File: rtl/psd_pkg.sv
// Shared types, default widths and the accumulate helper for the PSD bin averager.
package psd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } psd_state_e;

  localparam int unsigned MAG_W_DEF = 32;
  localparam int unsigned ACC_W_DEF = 40;

  // Widest accumulator the helper supports.
  localparam int unsigned ADD_MAX_W = 64;

  // Adds two w-bit operands held in 64-bit containers; returns {carry, result}.
  // With sat set, a carry replaces the result by the all-ones w-bit value.
  function automatic logic [ADD_MAX_W:0] psd_add(
    input logic [ADD_MAX_W-1:0] a,
    input logic [ADD_MAX_W-1:0] b,
    input int unsigned          w,
    input logic                 sat
  );
    logic [ADD_MAX_W:0]   sum;
    logic [ADD_MAX_W-1:0] mask;
    logic                 carry;
    mask  = (w >= ADD_MAX_W) ? '1 : ((ADD_MAX_W'(1) << w) - ADD_MAX_W'(1));
    sum   = {1'b0, a} + {1'b0, b};
    carry = ((sum >> w) != '0);
    psd_add = {carry, (sat && carry) ? mask : (sum[ADD_MAX_W-1:0] & mask)};
  endfunction

endpackage

// File: rtl/psd_acc_ram.sv
// Per-bin accumulator storage: one write port, one synchronous read port.
module psd_acc_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port and registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/psd_bin_averager.sv
// Multi-bin PSD averager: accumulates 2^seg_log2 segments of N_BINS |X|^2 values,
// then drains (sum >> seg_log2) per bin over valid/ready.
// Build option: define PSD_SAT_EN to saturate on accumulator overflow (default wraps).
module psd_bin_averager
  import psd_pkg::*;
#(
  parameter int unsigned MAG_W    = MAG_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned N_BINS   = 64,
  parameter int unsigned MAX_LOG2 = 4,
  localparam int unsigned BIN_W   = $clog2(N_BINS),
  localparam int unsigned SEG_W   = $clog2(MAX_LOG2 + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SEG_W-1:0] seg_log2,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [BIN_W-1:0] out_bin,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned    CNT_W    = MAX_LOG2;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BINS - 1);
`ifdef PSD_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  psd_state_e       r_state, w_state_nxt;
  logic [SEG_W-1:0] r_seg, w_seg_clamped;
  logic [BIN_W-1:0] r_bin_cnt;
  logic [CNT_W-1:0] r_seg_cnt, w_seg_max;
  logic             r_in_ready, r_busy, r_done, r_ovf;
  logic             r_wr_pend, r_wr_first;
  logic [BIN_W-1:0] r_wr_bin;
  logic [MAG_W-1:0] r_wr_in;
  logic [BIN_W-1:0] r_rd_ptr, r_rd_bin;
  logic             r_rd_all, r_rd_vld;
  logic             r_out_valid, r_out_last, r_sk_vld;
  logic [ACC_W-1:0] r_out_data, r_sk_data;
  logic [BIN_W-1:0] r_out_bin, r_sk_bin;
  logic             w_start, w_final, w_drain_end, w_accept, w_out_hs, w_rd_issue, w_ram_re;
  logic             w_carry;
  logic [1:0]       w_occ;
  logic [BIN_W-1:0] w_ram_raddr;
  logic [ACC_W-1:0] w_ram_rdata, w_wdata, w_rd_scaled;
  logic [ADD_MAX_W:0] w_add;

  assign w_seg_clamped = (seg_log2 > SEG_W'(MAX_LOG2)) ? SEG_W'(MAX_LOG2) : seg_log2;
  assign w_seg_max     = CNT_W'((32'd1 << r_seg) - 32'd1);
  assign w_accept      = in_valid && r_in_ready;
  assign w_out_hs      = r_out_valid && out_ready;

  // Next-state decode; abort overrides everything, including a same-cycle start.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_final     = 1'b0;
    w_drain_end = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) begin w_state_nxt = ST_ACCUM; w_start = 1'b1; end
      ST_ACCUM: if (w_accept && (r_bin_cnt == LAST_BIN) && (r_seg_cnt == w_seg_max)) begin
                  w_state_nxt = ST_DRAIN; w_final = 1'b1;
                end
      ST_DRAIN: if (w_out_hs && r_out_last) begin w_state_nxt = ST_IDLE; w_drain_end = 1'b1; end
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_start     = 1'b0;
      w_final     = 1'b0;
      w_drain_end = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Status outputs derived from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0; r_in_ready <= 1'b0; r_done <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_in_ready <= (w_state_nxt == ST_ACCUM);
      r_done     <= w_drain_end;
    end
  end

  // Run configuration and bin/segment counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0; r_bin_cnt <= '0; r_seg_cnt <= '0;
    end else if (w_start) begin
      r_seg <= w_seg_clamped; r_bin_cnt <= '0; r_seg_cnt <= '0;
    end else if (w_accept) begin
      if (r_bin_cnt == LAST_BIN) begin
        r_bin_cnt <= '0;
        r_seg_cnt <= r_seg_cnt + CNT_W'(1);
      end else begin
        r_bin_cnt <= r_bin_cnt + BIN_W'(1);
      end
    end
  end

  // Read-modify-write stage 1: capture the accepted sample while its bin is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_pend <= 1'b0; r_wr_first <= 1'b0; r_wr_bin <= '0; r_wr_in <= '0;
    end else begin
      r_wr_pend <= w_accept && !abort;
      if (w_accept) begin
        r_wr_bin   <= r_bin_cnt;
        r_wr_in    <= in_data;
        r_wr_first <= (r_seg_cnt == '0);
      end
    end
  end

  // Stage 2: segment 0 overwrites, later segments add to the stored value.
  assign w_add   = psd_add(ADD_MAX_W'(w_ram_rdata), ADD_MAX_W'(r_wr_in), ACC_W, SAT_EN);
  assign w_wdata = r_wr_first ? ACC_W'(r_wr_in) : ACC_W'(w_add);
  assign w_carry = !r_wr_first && w_add[ADD_MAX_W];

  // Sticky overflow, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_ovf <= 1'b0;
    else if (w_start)                r_ovf <= 1'b0;
    else if (r_wr_pend && w_carry)   r_ovf <= 1'b1;
  end

  // Drain reads are issued only while the output register plus skid can absorb them.
  assign w_occ      = 2'(r_out_valid) + 2'(r_sk_vld) + 2'(r_rd_vld) - 2'(w_out_hs);
  assign w_rd_issue = (r_state == ST_DRAIN) && !r_rd_all && !abort && (w_occ < 2'd2);
  assign w_ram_re   = w_accept || w_rd_issue;
  assign w_ram_raddr = (r_state == ST_DRAIN) ? r_rd_ptr : r_bin_cnt;
  assign w_rd_scaled = w_ram_rdata >> r_seg;

  // Drain read pointer and read-data-valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0; r_rd_all <= 1'b0; r_rd_vld <= 1'b0; r_rd_bin <= '0;
    end else begin
      r_rd_vld <= w_rd_issue;
      if (w_start) begin
        r_rd_ptr <= '0; r_rd_all <= 1'b0;
      end else if (w_rd_issue) begin
        r_rd_bin <= r_rd_ptr;
        if (r_rd_ptr == LAST_BIN) r_rd_all <= 1'b1;
        else                      r_rd_ptr <= r_rd_ptr + BIN_W'(1);
      end
    end
  end

  // Output register with a one-entry skid; the skid always holds the older beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0; r_out_data <= '0; r_out_bin <= '0; r_out_last <= 1'b0;
      r_sk_vld <= 1'b0; r_sk_data <= '0; r_sk_bin <= '0;
    end else if (abort) begin
      r_out_valid <= 1'b0; r_out_last <= 1'b0; r_sk_vld <= 1'b0;
    end else if (r_out_valid && !out_ready) begin
      if (r_rd_vld) begin
        r_sk_vld <= 1'b1; r_sk_data <= w_rd_scaled; r_sk_bin <= r_rd_bin;
      end
    end else if (r_sk_vld) begin
      r_out_valid <= 1'b1; r_out_data <= r_sk_data; r_out_bin <= r_sk_bin;
      r_out_last  <= (r_sk_bin == LAST_BIN);
      if (r_rd_vld) begin
        r_sk_data <= w_rd_scaled; r_sk_bin <= r_rd_bin;
      end else begin
        r_sk_vld <= 1'b0;
      end
    end else if (r_rd_vld) begin
      r_out_valid <= 1'b1; r_out_data <= w_rd_scaled; r_out_bin <= r_rd_bin;
      r_out_last  <= (r_rd_bin == LAST_BIN);
    end else begin
      r_out_valid <= 1'b0; r_out_last <= 1'b0;
    end
  end

  psd_acc_ram #(.DEPTH(N_BINS), .WIDTH(ACC_W)) u_ram (
    .clk     (clk),
    .i_we    (r_wr_pend),
    .i_waddr (r_wr_bin),
    .i_wdata (w_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bin   = r_out_bin;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_psd_bin_averager.sv
// Directed bench for psd_bin_averager with an arithmetic reference model and
// a per-beat scoreboard. Small configuration so overflow is reachable.
module tb_psd_bin_averager;

  localparam int unsigned MAG_W    = 10;
  localparam int unsigned ACC_W    = 11;
  localparam int unsigned N_BINS   = 4;
  localparam int unsigned MAX_LOG2 = 2;
  localparam int unsigned BIN_W    = 2;
  localparam int unsigned SEG_W    = 2;
  localparam longint      ACC_MAX  = (64'd1 << ACC_W) - 1;
`ifdef PSD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk, rst_n, start, abort, in_valid, in_ready, out_valid, out_ready;
  logic             out_last, busy, done, ovf;
  logic [SEG_W-1:0] seg_log2;
  logic [MAG_W-1:0] in_data;
  logic [ACC_W-1:0] out_data;
  logic [BIN_W-1:0] out_bin;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [ACC_W-1:0] q_data[$];
  int               q_bin[$];
  logic [ACC_W-1:0] got_data [N_BINS];
  bit               hold_chk = 1'b0;
  logic [ACC_W-1:0] h_data;
  logic [BIN_W-1:0] h_bin;

  psd_bin_averager #(.MAG_W(MAG_W), .ACC_W(ACC_W), .N_BINS(N_BINS), .MAX_LOG2(MAX_LOG2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seg_log2(seg_log2),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bin(out_bin),
    .out_last(out_last), .busy(busy), .done(done), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample value for a given test mode, segment and bin.
  function automatic int gen(input int mode, input int seg, input int bin);
    case (mode)
      0: return 16;
      1: return bin * 100;
      2: return 1023;
      3: return (seg < 3) ? 1023 : 1;
      4: return bin * 5 + seg * 3 + 1;
      5: return 8;
      default: return 999;
    endcase
  endfunction

  task automatic send(input int d);
    int w;
    in_data  = MAG_W'(d);
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 20) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  // One complete run: model the expected averages, drive samples, drain.
  task automatic run(input int mode, input int seg_req, input bit bp, input int gap, input bit inject);
    int     seg_eff, nseg, d0, cc;
    longint s, t;
    bit     exp_ovf;
    seg_eff = (seg_req > int'(MAX_LOG2)) ? int'(MAX_LOG2) : seg_req;
    nseg    = 1 << seg_eff;
    exp_ovf = 1'b0;
    for (int b = 0; b < int'(N_BINS); b++) begin
      s = 0;
      for (int k = 0; k < nseg; k++) begin
        if (k == 0) s = gen(mode, k, b);
        else begin
          t = s + gen(mode, k, b);
          if (t > ACC_MAX) begin
            exp_ovf = 1'b1;
            s = SAT ? ACC_MAX : t - (ACC_MAX + 1);
          end else s = t;
        end
      end
      q_data.push_back(ACC_W'(s >> seg_eff));
      q_bin.push_back(b);
      got_data[b] = '0;
    end
    d0 = done_cnt;
    out_ready = 1'b1;
    seg_log2 = SEG_W'(seg_req);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < nseg; k++) begin
      for (int b = 0; b < int'(N_BINS); b++) begin
        if (inject && k == 1 && b == 2) begin
          start = 1'b1;
          seg_log2 = '0;
        end
        send(gen(mode, k, b));
        start = 1'b0;
        if (gap > 0 && ((k * int'(N_BINS) + b) % gap) == 0) tick();
      end
    end
    cc = 0;
    while (busy && cc < 200) begin
      out_ready = bp ? ((cc % 4) == 0 || (cc % 4) == 3) : 1'b1;
      tick();
      cc++;
    end
    chk("drain_finished", longint'(busy), 0);
    out_ready = 1'b1;
    tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("ovf", longint'(ovf), longint'(exp_ovf));
    chk("beats_left", q_data.size(), 0);
    q_data.delete();
    q_bin.delete();
  endtask

  // Scoreboard: every handshake must match the model, stalled beats must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (hold_chk && busy) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_data", longint'(out_data), longint'(h_data));
        chk("hold_bin", longint'(out_bin), longint'(h_bin));
      end
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk("out_data", longint'(out_data), longint'(q_data[0]));
          chk("out_bin", longint'(out_bin), longint'(q_bin[0]));
          chk("out_last", longint'(out_last), longint'(q_bin[0] == int'(N_BINS) - 1));
          got_data[out_bin] = out_data;
          void'(q_data.pop_front());
          void'(q_bin.pop_front());
        end
      end
      hold_chk = out_valid && !out_ready;
      h_data   = out_data;
      h_bin    = out_bin;
    end
  end

  initial begin
    int d0, c;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seg_log2 = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_bin", longint'(out_bin), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ovf", longint'(ovf), 0);
    rst_n = 1'b1;
    tick();

    // Constant input over four segments.
    run(0, 2, 1'b0, 3, 1'b0);
    for (int b = 0; b < int'(N_BINS); b++) chk("lit_const", longint'(got_data[b]), 16);

    // Single segment: values pass through unscaled.
    run(1, 0, 1'b0, 0, 1'b0);
    for (int b = 0; b < int'(N_BINS); b++) chk("lit_pass", longint'(got_data[b]), b * 100);

    // All-ones overflow.
    run(2, 2, 1'b0, 0, 1'b0);
    chk("lit_ovf_flag", longint'(ovf), 1);
    for (int b = 0; b < int'(N_BINS); b++) chk("lit_ovf_all1", longint'(got_data[b]), 511);

    // Overflow then a small add: distinguishes saturate from wrap.
    run(3, 2, 1'b0, 0, 1'b0);
    for (int b = 0; b < int'(N_BINS); b++) chk("lit_ovf_mode", longint'(got_data[b]), SAT ? 511 : 255);

    // Drain backpressure; start also clears ovf.
    run(4, 1, 1'b1, 2, 1'b0);
    for (int b = 0; b < int'(N_BINS); b++) chk("lit_bp", longint'(got_data[b]), 5 * b + 2);

    // start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", longint'(busy), 0);
    tick();
    chk("start_abort_idle_rdy", longint'(in_ready), 0);

    // Abort mid-ACCUM (with a concurrent start), then a clean run.
    d0 = done_cnt;
    seg_log2 = 2'd2; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) send(gen(6, 0, 0));
    abort = 1'b1; start = 1'b1; tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_acc_busy", longint'(busy), 0);
    chk("abort_acc_rdy", longint'(in_ready), 0);
    tick();
    chk("abort_acc_stay", longint'(busy), 0);
    chk("abort_acc_done", done_cnt - d0, 0);
    run(5, 1, 1'b0, 0, 1'b0);
    for (int b = 0; b < int'(N_BINS); b++) chk("lit_after_abort", longint'(got_data[b]), 8);

    // Abort during a stalled drain: out_valid drops, no done.
    d0 = done_cnt;
    seg_log2 = '0; start = 1'b1; tick(); start = 1'b0;
    for (int b = 0; b < int'(N_BINS); b++) send(gen(1, 0, b));
    out_ready = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin tick(); c++; end
    chk("abort_drain_reach", longint'(out_valid), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_drain_valid", longint'(out_valid), 0);
    chk("abort_drain_busy", longint'(busy), 0);
    out_ready = 1'b1;
    tick(); tick();
    chk("abort_drain_done", done_cnt - d0, 0);

    // start while busy is ignored (seg_log2 stays at 2).
    run(0, 2, 1'b0, 0, 1'b1);
    for (int b = 0; b < int'(N_BINS); b++) chk("lit_busy_start", longint'(got_data[b]), 16);

    // seg_log2 above MAX_LOG2 clamps to MAX_LOG2.
    run(4, 3, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
